// File: rtl/reservation_station_pkg.sv
// Reservation station shared types: sizing, op encodings,
// entry layout and CDB snoop helper.
package reservation_station_pkg;

  localparam int RS_SIZE = 16;
  localparam int RS_LOG  = 4;
  localparam int ROB_LOG = 4;
  localparam int OP_LOG  = 5;

  typedef logic [OP_LOG-1:0]  op_t;
  typedef logic [ROB_LOG-1:0] rob_id_t;
  typedef logic [RS_LOG-1:0]  rs_idx_t;

  typedef enum logic [OP_LOG-1:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_SLL  = 5'd6,
    OP_SRL  = 5'd7,
    OP_SRA  = 5'd8,
    OP_SLT  = 5'd9,
    OP_SLTU = 5'd10
  } op_e;

  typedef struct packed {
    logic        valid;
    op_t         op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic        rj;
    logic        rk;
    rob_id_t     qj;
    rob_id_t     qk;
    logic [31:0] imm;
    logic [31:0] pc;
    rob_id_t     rob_id;
  } rs_entry_t;

  typedef struct packed {
    logic        valid;
    rob_id_t     rob_id;
    logic [31:0] value;
  } cdb_t;

  function automatic logic snoop_hit(
    input cdb_t    c,
    input rob_id_t q
  );
    return c.valid && (c.rob_id == q);
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Issue->RS dispatch bundle, CDB snoop inputs and
// the RS->ALU dispatch outputs.
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic        issue_enable;
  op_t         issue_op;
  logic [31:0] issue_Vj;
  logic [31:0] issue_Vk;
  logic        issue_Rj;
  logic        issue_Rk;
  rob_id_t     issue_Qj;
  rob_id_t     issue_Qk;
  logic [31:0] issue_Imm;
  logic [31:0] issue_CurPc;
  rob_id_t     issue_RobId;

  logic        alu_cdb_valid;
  rob_id_t     alu_cdb_RobId;
  logic [31:0] alu_cdb_value;
  logic        lsb_cdb_valid;
  rob_id_t     lsb_cdb_RobId;
  logic [31:0] lsb_cdb_value;

  logic        rs_full;
  logic        alu_enable;
  op_t         alu_op;
  logic [31:0] alu_Vj;
  logic [31:0] alu_Vk;
  logic [31:0] alu_Imm;
  logic [31:0] alu_CurPc;
  rob_id_t     alu_RobId;

  modport master (
    output issue_enable, issue_op,
    output issue_Vj, issue_Vk,
    output issue_Rj, issue_Rk,
    output issue_Qj, issue_Qk,
    output issue_Imm, issue_CurPc,
    output issue_RobId,
    output alu_cdb_valid, alu_cdb_RobId,
    output alu_cdb_value,
    output lsb_cdb_valid, lsb_cdb_RobId,
    output lsb_cdb_value,
    input  rs_full, alu_enable, alu_op,
    input  alu_Vj, alu_Vk, alu_Imm,
    input  alu_CurPc, alu_RobId
  );

  modport slave (
    input  issue_enable, issue_op,
    input  issue_Vj, issue_Vk,
    input  issue_Rj, issue_Rk,
    input  issue_Qj, issue_Qk,
    input  issue_Imm, issue_CurPc,
    input  issue_RobId,
    input  alu_cdb_valid, alu_cdb_RobId,
    input  alu_cdb_value,
    input  lsb_cdb_valid, lsb_cdb_RobId,
    input  lsb_cdb_value,
    output rs_full, alu_enable, alu_op,
    output alu_Vj, alu_Vk, alu_Imm,
    output alu_CurPc, alu_RobId
  );

endinterface

// File: rtl/reservation_station_rs_select.sv
// Two lowest-index priority encoders: first free slot
// and first slot with both operands ready.
module reservation_station_rs_select
  import reservation_station_pkg::*;
(
  input  logic [RS_SIZE-1:0] valid_vec,
  input  logic [RS_SIZE-1:0] ready_vec,
  output rs_idx_t            free_idx,
  output logic               free_found,
  output rs_idx_t            ready_idx,
  output logic               ready_found
);

  // Scan high to low so the lowest hit wins.
  always_comb begin
    free_idx    = '0;
    free_found  = 1'b0;
    ready_idx   = '0;
    ready_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_idx   = RS_LOG'(i);
        free_found = 1'b1;
      end
      if (ready_vec[i]) begin
        ready_idx   = RS_LOG'(i);
        ready_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Buffers non-memory ops until operands arrive via CDB,
// then hands one ready op per cycle to the ALU.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  reservation_station_if.slave bus
);

  rs_entry_t          ent [RS_SIZE];
  logic [RS_SIZE-1:0] valid_vec;
  logic [RS_SIZE-1:0] ready_vec;
  rs_idx_t            free_idx;
  logic               free_found;
  rs_idx_t            ready_idx;
  logic               ready_found;
  cdb_t               alu_cdb;
  cdb_t               lsb_cdb;
  rs_entry_t          new_ent;

  logic        alu_enable_q;
  op_t         alu_op_q;
  logic [31:0] alu_vj_q;
  logic [31:0] alu_vk_q;
  logic [31:0] alu_imm_q;
  logic [31:0] alu_pc_q;
  rob_id_t     alu_rob_q;

  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      valid_vec[i] = ent[i].valid;
      ready_vec[i] = ent[i].valid
                   && ent[i].rj
                   && ent[i].rk;
    end
  end

  reservation_station_rs_select u_sel (
    .valid_vec   (valid_vec),
    .ready_vec   (ready_vec),
    .free_idx    (free_idx),
    .free_found  (free_found),
    .ready_idx   (ready_idx),
    .ready_found (ready_found)
  );

  always_comb begin
    alu_cdb.valid  = bus.alu_cdb_valid;
    alu_cdb.rob_id = bus.alu_cdb_RobId;
    alu_cdb.value  = bus.alu_cdb_value;
    lsb_cdb.valid  = bus.lsb_cdb_valid;
    lsb_cdb.rob_id = bus.lsb_cdb_RobId;
    lsb_cdb.value  = bus.lsb_cdb_value;
  end

  // Incoming entry, with same-cycle CDB forwarding.
  always_comb begin
    new_ent        = '0;
    new_ent.valid  = 1'b1;
    new_ent.op     = bus.issue_op;
    new_ent.vj     = bus.issue_Vj;
    new_ent.vk     = bus.issue_Vk;
    new_ent.rj     = bus.issue_Rj;
    new_ent.rk     = bus.issue_Rk;
    new_ent.qj     = bus.issue_Qj;
    new_ent.qk     = bus.issue_Qk;
    new_ent.imm    = bus.issue_Imm;
    new_ent.pc     = bus.issue_CurPc;
    new_ent.rob_id = bus.issue_RobId;
    if (!bus.issue_Rj) begin
      if (snoop_hit(alu_cdb, bus.issue_Qj)) begin
        new_ent.vj = alu_cdb.value;
        new_ent.rj = 1'b1;
      end else if (snoop_hit(lsb_cdb, bus.issue_Qj)) begin
        new_ent.vj = lsb_cdb.value;
        new_ent.rj = 1'b1;
      end
    end
    if (!bus.issue_Rk) begin
      if (snoop_hit(alu_cdb, bus.issue_Qk)) begin
        new_ent.vk = alu_cdb.value;
        new_ent.rk = 1'b1;
      end else if (snoop_hit(lsb_cdb, bus.issue_Qk)) begin
        new_ent.vk = lsb_cdb.value;
        new_ent.rk = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent[i] <= '0;
      end
      alu_enable_q <= 1'b0;
      alu_op_q     <= '0;
      alu_vj_q     <= '0;
      alu_vk_q     <= '0;
      alu_imm_q    <= '0;
      alu_pc_q     <= '0;
      alu_rob_q    <= '0;
    end else if (rdy) begin
      if (rollback) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          ent[i].valid <= 1'b0;
        end
        alu_enable_q <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent[i].valid && !ent[i].rj) begin
            if (snoop_hit(alu_cdb, ent[i].qj)) begin
              ent[i].vj <= alu_cdb.value;
              ent[i].rj <= 1'b1;
            end else if (snoop_hit(lsb_cdb, ent[i].qj)) begin
              ent[i].vj <= lsb_cdb.value;
              ent[i].rj <= 1'b1;
            end
          end
          if (ent[i].valid && !ent[i].rk) begin
            if (snoop_hit(alu_cdb, ent[i].qk)) begin
              ent[i].vk <= alu_cdb.value;
              ent[i].rk <= 1'b1;
            end else if (snoop_hit(lsb_cdb, ent[i].qk)) begin
              ent[i].vk <= lsb_cdb.value;
              ent[i].rk <= 1'b1;
            end
          end
        end
        alu_enable_q <= ready_found;
        if (ready_found) begin
          alu_op_q  <= ent[ready_idx].op;
          alu_vj_q  <= ent[ready_idx].vj;
          alu_vk_q  <= ent[ready_idx].vk;
          alu_imm_q <= ent[ready_idx].imm;
          alu_pc_q  <= ent[ready_idx].pc;
          alu_rob_q <= ent[ready_idx].rob_id;
          ent[ready_idx].valid <= 1'b0;
        end
        // Free slot is never the dispatching one.
        if (bus.issue_enable && free_found) begin
          ent[free_idx] <= new_ent;
        end
      end
    end
  end

  assign bus.rs_full    = &valid_vec;
  assign bus.alu_enable = alu_enable_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_Vj     = alu_vj_q;
  assign bus.alu_Vk     = alu_vk_q;
  assign bus.alu_Imm    = alu_imm_q;
  assign bus.alu_CurPc  = alu_pc_q;
  assign bus.alu_RobId  = alu_rob_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with a slot-level
// behavioural model checked every cycle.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic rollback;

  reservation_station_if bus();

  reservation_station dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    bit          v;
    logic [31:0] op, vj, vk, imm, pc;
    bit          rj, rk;
    int unsigned qj, qk, rob;
  } m_ent_t;

  m_ent_t      m [RS_SIZE];
  bit          started = 0;
  bit          m_en;
  logic [31:0] m_op, m_vj, m_vk, m_imm, m_pc, m_rob;

  function automatic int mcount();
    int n = 0;
    for (int i = 0; i < RS_SIZE; i++) if (m[i].v) n++;
    return n;
  endfunction

  // Value a CDB provides for producer q, if any.
  function automatic bit cdb_lookup(input int unsigned q,
                                    output logic [31:0] val);
    val = 0;
    if (bus.alu_cdb_valid && bus.alu_cdb_RobId == q) begin
      val = bus.alu_cdb_value;
      return 1;
    end
    if (bus.lsb_cdb_valid && bus.lsb_cdb_RobId == q) begin
      val = bus.lsb_cdb_value;
      return 1;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    int sel, fr;
    bit full;
    logic [31:0] val;
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) m[i].v = 0;
      m_en = 0; m_op = 0; m_vj = 0; m_vk = 0;
      m_imm = 0; m_pc = 0; m_rob = 0;
      started = 1;
    end else if (started && rdy) begin
      if (rollback) begin
        for (int i = 0; i < RS_SIZE; i++) m[i].v = 0;
        m_en = 0;
      end else begin
        sel = -1; fr = -1;
        full = (mcount() == RS_SIZE);
        for (int i = 0; i < RS_SIZE; i++) begin
          if (sel < 0 && m[i].v && m[i].rj && m[i].rk) sel = i;
          if (fr < 0 && !m[i].v) fr = i;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
          if (m[i].v && !m[i].rj && cdb_lookup(m[i].qj, val)) begin
            m[i].vj = val; m[i].rj = 1;
          end
          if (m[i].v && !m[i].rk && cdb_lookup(m[i].qk, val)) begin
            m[i].vk = val; m[i].rk = 1;
          end
        end
        if (sel >= 0) begin
          m_en = 1;
          m_op = m[sel].op; m_vj = m[sel].vj; m_vk = m[sel].vk;
          m_imm = m[sel].imm; m_pc = m[sel].pc; m_rob = m[sel].rob;
          m[sel].v = 0;
        end else begin
          m_en = 0;
        end
        if (bus.issue_enable && !full) begin
          m[fr].v   = 1;
          m[fr].op  = 32'(bus.issue_op);
          m[fr].imm = bus.issue_Imm;
          m[fr].pc  = bus.issue_CurPc;
          m[fr].rob = bus.issue_RobId;
          m[fr].qj  = bus.issue_Qj;
          m[fr].qk  = bus.issue_Qk;
          m[fr].rj  = bus.issue_Rj;
          m[fr].rk  = bus.issue_Rk;
          m[fr].vj  = bus.issue_Vj;
          m[fr].vk  = bus.issue_Vk;
          if (!bus.issue_Rj && cdb_lookup(bus.issue_Qj, val)) begin
            m[fr].vj = val; m[fr].rj = 1;
          end
          if (!bus.issue_Rk && cdb_lookup(bus.issue_Qk, val)) begin
            m[fr].vk = val; m[fr].rk = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_rs_full", 32'(bus.rs_full),
            32'(mcount() == RS_SIZE));
      check("m_alu_enable", 32'(bus.alu_enable), 32'(m_en));
      if (m_en) begin
        check("m_alu_op", 32'(bus.alu_op), m_op);
        check("m_alu_Vj", bus.alu_Vj, m_vj);
        check("m_alu_Vk", bus.alu_Vk, m_vk);
        check("m_alu_Imm", bus.alu_Imm, m_imm);
        check("m_alu_CurPc", bus.alu_CurPc, m_pc);
        check("m_alu_RobId", 32'(bus.alu_RobId), m_rob);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.issue_enable  = 0;
    bus.issue_op      = '0;
    bus.issue_Vj      = '0;
    bus.issue_Vk      = '0;
    bus.issue_Rj      = 0;
    bus.issue_Rk      = 0;
    bus.issue_Qj      = '0;
    bus.issue_Qk      = '0;
    bus.issue_Imm     = '0;
    bus.issue_CurPc   = '0;
    bus.issue_RobId   = '0;
    bus.alu_cdb_valid = 0;
    bus.alu_cdb_RobId = '0;
    bus.alu_cdb_value = '0;
    bus.lsb_cdb_valid = 0;
    bus.lsb_cdb_RobId = '0;
    bus.lsb_cdb_value = '0;
  endtask

  task automatic issue(input logic [31:0] vj, vk,
                       input bit rj, rk,
                       input int unsigned qj, qk, rob);
    bus.issue_enable = 1;
    bus.issue_op     = OP_ADD;
    bus.issue_Vj     = vj;
    bus.issue_Vk     = vk;
    bus.issue_Rj     = rj;
    bus.issue_Rk     = rk;
    bus.issue_Qj     = rob_id_t'(qj);
    bus.issue_Qk     = rob_id_t'(qk);
    bus.issue_Imm    = 32'h100 + rob;
    bus.issue_CurPc  = 32'h8000_0000 + (rob << 2);
    bus.issue_RobId  = rob_id_t'(rob);
  endtask

  initial begin
    clear_in();
    rst = 1; rdy = 1; rollback = 0;
    tick();
    check("rst_alu_enable", 32'(bus.alu_enable), 0);
    check("rst_rs_full", 32'(bus.rs_full), 0);
    check("rst_alu_Vj", bus.alu_Vj, 0);
    rst = 0;

    // ready op: enable two cycles after issue
    issue(32'd3, 32'd4, 1, 1, 0, 0, 1);
    tick();
    clear_in();
    check("lat_t1_en", 32'(bus.alu_enable), 0);
    tick();
    check("lat_t2_en", 32'(bus.alu_enable), 1);
    check("lat_Vj", bus.alu_Vj, 3);
    check("lat_Vk", bus.alu_Vk, 4);
    check("lat_Imm", bus.alu_Imm, 32'h101);
    check("lat_Pc", bus.alu_CurPc, 32'h8000_0004);
    tick();
    check("lat_t3_en", 32'(bus.alu_enable), 0);

    // wakeup by ALU CDB
    issue(32'hdead, 32'd5, 0, 1, 3, 0, 4);
    tick();
    clear_in();
    repeat (3) tick();
    bus.alu_cdb_valid = 1;
    bus.alu_cdb_RobId = 3;
    bus.alu_cdb_value = 7;
    tick();
    clear_in();
    check("wake_t1_en", 32'(bus.alu_enable), 0);
    tick();
    check("wake_en", 32'(bus.alu_enable), 1);
    check("wake_Vj", bus.alu_Vj, 7);
    check("wake_Vk", bus.alu_Vk, 5);
    check("wake_Rob", 32'(bus.alu_RobId), 4);
    tick();

    // forward from LSB CDB on issue
    issue(32'h0, 32'd1, 0, 1, 2, 0, 5);
    bus.lsb_cdb_valid = 1;
    bus.lsb_cdb_RobId = 2;
    bus.lsb_cdb_value = 32'h10;
    tick();
    clear_in();
    tick();
    check("fwd_en", 32'(bus.alu_enable), 1);
    check("fwd_Vj", bus.alu_Vj, 32'h10);
    check("fwd_Rob", 32'(bus.alu_RobId), 5);
    tick();

    // fill all 16 slots waiting on id 9
    for (int i = 0; i < RS_SIZE; i++) begin
      issue(32'h0, 32'(i), 0, 1, 9, 0, i);
      tick();
    end
    check("full_set", 32'(bus.rs_full), 1);
    issue(32'd1, 32'd2, 1, 1, 0, 0, 14);
    bus.issue_Imm = 32'hbad;
    tick();
    clear_in();
    check("full_17th_ign", 32'(bus.rs_full), 1);
    bus.alu_cdb_valid = 1;
    bus.alu_cdb_RobId = 9;
    bus.alu_cdb_value = 32'h99;
    tick();
    clear_in();
    check("full_no_disp", 32'(bus.alu_enable), 0);
    check("full_still", 32'(bus.rs_full), 1);
    for (int i = 0; i < RS_SIZE; i++) begin
      tick();
      check("drain_en", 32'(bus.alu_enable), 1);
      check("drain_Rob", 32'(bus.alu_RobId), 32'(i));
      check("drain_Vj", bus.alu_Vj, 32'h99);
      check("drain_Vk", bus.alu_Vk, 32'(i));
      if (i == 0) check("full_drop", 32'(bus.rs_full), 0);
    end
    tick();
    check("drain_done", 32'(bus.alu_enable), 0);

    // rollback flushes pending and drops issue
    for (int i = 0; i < 3; i++) begin
      issue(32'h0, 32'd1, 0, 1, 6, 0, i + 1);
      tick();
    end
    issue(32'd1, 32'd1, 1, 1, 0, 0, 12);
    rollback = 1;
    tick();
    rollback = 0;
    clear_in();
    check("rb_en", 32'(bus.alu_enable), 0);
    check("rb_full", 32'(bus.rs_full), 0);
    bus.alu_cdb_valid = 1;
    bus.alu_cdb_RobId = 6;
    bus.alu_cdb_value = 32'h66;
    tick();
    clear_in();
    tick();
    check("rb_empty", 32'(bus.alu_enable), 0);
    tick();
    check("rb_empty2", 32'(bus.alu_enable), 0);

    // rdy=0 freezes everything
    issue(32'h0, 32'd2, 0, 1, 8, 0, 3);
    tick();
    issue(32'h70, 32'h07, 1, 1, 0, 0, 7);
    tick();
    rdy = 0;
    issue(32'd9, 32'd9, 1, 1, 0, 0, 9);
    bus.alu_cdb_valid = 1;
    bus.alu_cdb_RobId = 8;
    bus.alu_cdb_value = 32'h88;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("frz_en", 32'(bus.alu_enable), 0);
    end
    rdy = 1;
    clear_in();
    tick();
    check("res_en", 32'(bus.alu_enable), 1);
    check("res_Rob", 32'(bus.alu_RobId), 7);
    check("res_Vj", bus.alu_Vj, 32'h70);
    tick();
    check("res_lost_cdb", 32'(bus.alu_enable), 0);
    tick();
    check("res_lost_cdb2", 32'(bus.alu_enable), 0);
    rollback = 1;
    tick();
    rollback = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
